// File: rtl/register_file_pkg.sv
// Shared encodings for the out-of-order core: register indices, RoB tags, sentinels.
// Common to the RoB, reservation stations, LSB, dispatcher and register file.
package register_file_pkg;

    localparam int REG_WIDTH    = 5;
    localparam int EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int RoB_WIDTH    = 8;
    localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
    localparam int NUM_REGS     = 1 << REG_WIDTH;

    typedef logic [EX_REG_WIDTH-1:0] ex_reg_t;
    typedef logic [RoB_WIDTH-1:0]    rob_idx_t;
    typedef logic [EX_RoB_WIDTH-1:0] ex_rob_t;
    typedef logic [31:0]             word_t;

    localparam ex_reg_t NON_REG = 6'b100000;
    localparam ex_rob_t NON_DEP = 9'b100000000;

    // True for an index that names a writable architectural register (not x0, not "none").
    function automatic logic is_real_reg(input ex_reg_t r);
        return !r[EX_REG_WIDTH-1] && (r[REG_WIDTH-1:0] != '0);
    endfunction

    function automatic ex_rob_t live_tag(input rob_idx_t idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/register_file_rf_read_port.sv
// One dispatcher operand lookup: returns the architectural value or the producing RoB tag,
// forwarding a same-cycle commit whose tag still owns the register.
module rf_read_port
    import register_file_pkg::*;
(
    input  ex_reg_t  rs,
    input  word_t    values [NUM_REGS],
    input  ex_rob_t  tags   [NUM_REGS],
    input  logic     commit_en,
    input  ex_reg_t  commit_rd,
    input  rob_idx_t commit_index,
    input  word_t    commit_value,
    output word_t    v,
    output ex_rob_t  q
);

    logic [REG_WIDTH-1:0] idx;
    assign idx = rs[REG_WIDTH-1:0];

    // NOTE: every output gets a default before any branch, so no path leaves it unassigned
    // and no latch can be inferred.
    always_comb begin
        v = '0;
        q = NON_DEP;
        if (is_real_reg(rs)) begin
            if (commit_en && commit_rd == rs && tags[idx] == live_tag(commit_index)) begin
                v = commit_value;
            end else begin
                v = values[idx];
                q = tags[idx];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename-tag table; receives RoB commits and
// answers two combinational operand queries for the dispatcher.
module register_file
    import register_file_pkg::*;
(
    input  logic     Sys_clk,
    input  logic     Sys_rst,
    input  logic     Sys_rdy,
    input  ex_reg_t  DPRF_rs1,
    input  ex_reg_t  DPRF_rs2,
    input  logic     DPRF_en,
    input  ex_reg_t  DPRF_rd,
    input  rob_idx_t DPRF_RoB_index,
    output word_t    RFDP_Vj,
    output ex_rob_t  RFDP_Qj,
    output word_t    RFDP_Vk,
    output ex_rob_t  RFDP_Qk,
    input  logic     RoBRF_pre_judge,
    input  logic     RoBRF_en,
    input  rob_idx_t RoBRF_RoB_index,
    input  ex_reg_t  RoBRF_rd,
    input  word_t    RoBRF_value
);

    word_t   values [NUM_REGS];
    ex_rob_t tags   [NUM_REGS];

    logic [REG_WIDTH-1:0] commit_idx;
    logic [REG_WIDTH-1:0] rename_idx;
    assign commit_idx = RoBRF_rd[REG_WIDTH-1:0];
    assign rename_idx = DPRF_rd[REG_WIDTH-1:0];

    // NOTE: both arrays are reset because queries must read 0/NON_DEP straight out of
    // reset; this makes them flops rather than RAM, which is fine at 32 entries.
    // Non-blocking assignments throughout: later writes in this block override earlier
    // ones to the same entry, which is how rename beats commit and flush beats both.
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                values[i] <= '0;
                tags[i]   <= NON_DEP;
            end
        end else if (Sys_rdy) begin
            if (RoBRF_en && is_real_reg(RoBRF_rd)) begin
                values[commit_idx] <= RoBRF_value;
                // A younger rename of the same register keeps its tag.
                if (tags[commit_idx] == live_tag(RoBRF_RoB_index)) begin
                    tags[commit_idx] <= NON_DEP;
                end
            end
            if (!RoBRF_pre_judge) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    tags[i] <= NON_DEP;
                end
            end else if (DPRF_en && is_real_reg(DPRF_rd)) begin
                tags[rename_idx] <= live_tag(DPRF_RoB_index);
            end
        end
    end

    rf_read_port u_port_j (
        .rs           (DPRF_rs1),
        .values       (values),
        .tags         (tags),
        .commit_en    (RoBRF_en),
        .commit_rd    (RoBRF_rd),
        .commit_index (RoBRF_RoB_index),
        .commit_value (RoBRF_value),
        .v            (RFDP_Vj),
        .q            (RFDP_Qj)
    );

    rf_read_port u_port_k (
        .rs           (DPRF_rs2),
        .values       (values),
        .tags         (tags),
        .commit_en    (RoBRF_en),
        .commit_rd    (RoBRF_rd),
        .commit_index (RoBRF_RoB_index),
        .commit_value (RoBRF_value),
        .v            (RFDP_Vk),
        .q            (RFDP_Qk)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed scenarios plus randomized traffic against an array-based model of the
// register file's architectural values and outstanding rename tags.
module tb_register_file;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic [5:0]  DPRF_rs1, DPRF_rs2, DPRF_rd;
    logic        DPRF_en;
    logic [7:0]  DPRF_RoB_index;
    logic [31:0] RFDP_Vj, RFDP_Vk;
    logic [8:0]  RFDP_Qj, RFDP_Qk;
    logic        RoBRF_pre_judge, RoBRF_en;
    logic [7:0]  RoBRF_RoB_index;
    logic [5:0]  RoBRF_rd;
    logic [31:0] RoBRF_value;

    localparam logic [5:0] NOREG = 6'b100000;
    localparam logic [8:0] NODEP = 9'b100000000;

    register_file dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2), .DPRF_en(DPRF_en),
        .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
        .RFDP_Vj(RFDP_Vj), .RFDP_Qj(RFDP_Qj), .RFDP_Vk(RFDP_Vk), .RFDP_Qk(RFDP_Qk),
        .RoBRF_pre_judge(RoBRF_pre_judge), .RoBRF_en(RoBRF_en),
        .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd), .RoBRF_value(RoBRF_value)
    );

    always #5 Sys_clk = ~Sys_clk;

    int checks = 0;
    int passed = 0;

    // Model: architectural values and the outstanding RoB index per register (-1 = none).
    logic [31:0] m_val [32];
    int          m_tag [32];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [8:0] tag_enc(input int t);
        return (t < 0) ? NODEP : 9'(t);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = -1;
        end
    endtask

    task automatic model_query(input logic [5:0] rs, output logic [31:0] v, output logic [8:0] q);
        int r;
        r = int'(rs);
        v = '0;
        q = NODEP;
        if (r >= 32 || r == 0) return;
        if (RoBRF_en && RoBRF_rd == rs && m_tag[r] == int'(RoBRF_RoB_index)) begin
            v = RoBRF_value;
            return;
        end
        v = m_val[r];
        q = tag_enc(m_tag[r]);
    endtask

    // Apply one clock edge's worth of architectural effect using the current inputs.
    task automatic model_edge();
        int crd, drd;
        int nt [32];
        if (!Sys_rdy) return;
        crd = int'(RoBRF_rd);
        drd = int'(DPRF_rd);
        nt = m_tag;
        if (RoBRF_en && crd < 32 && crd != 0) begin
            m_val[crd] = RoBRF_value;
            if (m_tag[crd] == int'(RoBRF_RoB_index)) nt[crd] = -1;
        end
        if (!RoBRF_pre_judge) begin
            for (int i = 0; i < 32; i++) nt[i] = -1;
        end else if (DPRF_en && drd < 32 && drd != 0) begin
            nt[drd] = int'(DPRF_RoB_index);
        end
        m_tag = nt;
    endtask

    task automatic idle();
        Sys_rdy = 1'b1; DPRF_rs1 = NOREG; DPRF_rs2 = NOREG;
        DPRF_en = 1'b0; DPRF_rd = NOREG; DPRF_RoB_index = '0;
        RoBRF_pre_judge = 1'b1; RoBRF_en = 1'b0; RoBRF_RoB_index = '0;
        RoBRF_rd = NOREG; RoBRF_value = '0;
    endtask

    // Check both query ports against the model, then take one clock edge.
    task automatic step();
        logic [31:0] v;
        logic [8:0]  q;
        #1;
        model_query(DPRF_rs1, v, q);
        check("Vj", RFDP_Vj, v);
        check("Qj", 32'(RFDP_Qj), 32'(q));
        model_query(DPRF_rs2, v, q);
        check("Vk", RFDP_Vk, v);
        check("Qk", 32'(RFDP_Qk), 32'(q));
        model_edge();
        @(posedge Sys_clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [5:0] rd, input logic [7:0] idx);
        DPRF_en = 1'b1; DPRF_rd = rd; DPRF_RoB_index = idx;
    endtask

    task automatic commit(input logic [5:0] rd, input logic [7:0] idx, input logic [31:0] val);
        RoBRF_en = 1'b1; RoBRF_rd = rd; RoBRF_RoB_index = idx; RoBRF_value = val;
    endtask

    task automatic peek(input string name, input logic [5:0] rs,
                        input logic [31:0] exp_v, input logic [8:0] exp_q);
        DPRF_rs1 = rs;
        #1;
        check({name, "_V"}, RFDP_Vj, exp_v);
        check({name, "_Q"}, 32'(RFDP_Qj), 32'(exp_q));
    endtask

    logic [5:0] rnd_rd;
    int         pick;

    initial begin
        idle();
        Sys_rst = 1'b1;
        model_reset();
        #2;
        peek("rst_x5", 6'd5, 32'h0, NODEP);
        #10;
        Sys_rst = 1'b0;
        @(posedge Sys_clk);
        #1;

        // 1: preload x5=7 with tag 3, then async reset clears it with no clock edge.
        commit(6'd5, 8'd0, 32'd7); step();
        rename(6'd5, 8'd3); step();
        peek("pre_rst", 6'd5, 32'd7, 9'd3);
        Sys_rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_V", RFDP_Vj, 32'h0);
        check("async_rst_Q", 32'(RFDP_Qj), 32'(NODEP));
        @(posedge Sys_clk);
        #2;
        Sys_rst = 1'b0;
        @(posedge Sys_clk);
        #1;
        idle();

        // 2: rename then commit with same-cycle bypass.
        rename(6'd3, 8'd4); step();
        peek("ren_x3", 6'd3, 32'h0, 9'd4);
        commit(6'd3, 8'd4, 32'h55);
        peek("bypass_x3", 6'd3, 32'h55, NODEP);
        step();
        peek("retired_x3", 6'd3, 32'h55, NODEP);

        // 3: stale commit keeps the younger tag.
        rename(6'd3, 8'd4); step();
        rename(6'd3, 8'd9); step();
        commit(6'd3, 8'd4, 32'd1);
        peek("stale_nobypass", 6'd3, 32'h55, 9'd9);
        step();
        peek("stale_x3", 6'd3, 32'd1, 9'd9);

        // 4: simultaneous commit and rename on x7.
        rename(6'd7, 8'd2); step();
        commit(6'd7, 8'd2, 32'h77); rename(6'd7, 8'd6); step();
        peek("sim_x7", 6'd7, 32'h77, 9'd6);

        // 5: flush with commit and a dropped rename.
        rename(6'd1, 8'd1); step();
        rename(6'd2, 8'd2); step();
        RoBRF_pre_judge = 1'b0;
        commit(6'd1, 8'd1, 32'hAB); rename(6'd4, 8'd5);
        DPRF_rs2 = 6'd2;
        step();
        peek("flush_x1", 6'd1, 32'hAB, NODEP);
        peek("flush_x2", 6'd2, 32'h0, NODEP);
        peek("flush_x4", 6'd4, 32'h0, NODEP);
        peek("flush_x3", 6'd3, 32'd1, NODEP);

        // 6: x0 is never written; NON_REG commit and Sys_rdy=0 leave state alone.
        rename(6'd0, 8'd8); commit(6'd0, 8'd8, 32'd9); step();
        peek("x0", 6'd0, 32'h0, NODEP);
        commit(NOREG, 8'd3, 32'h123); step();
        peek("nonreg_x1", 6'd1, 32'hAB, NODEP);
        Sys_rdy = 1'b0;
        commit(6'd1, 8'd0, 32'hDEAD); rename(6'd1, 8'd12); step();
        peek("hold_x1", 6'd1, 32'hAB, NODEP);
        peek("hold_x0", NOREG, 32'h0, NODEP);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            Sys_rdy         = ($urandom_range(0, 9) != 0);
            RoBRF_pre_judge = ($urandom_range(0, 19) != 0);
            DPRF_rs1 = ($urandom_range(0, 9) == 0) ? NOREG : 6'($urandom_range(0, 31));
            DPRF_rs2 = ($urandom_range(0, 9) == 0) ? NOREG : 6'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                rename(($urandom_range(0, 15) == 0) ? NOREG : 6'($urandom_range(0, 31)),
                       8'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, 31);
                rnd_rd = ($urandom_range(0, 15) == 0) ? NOREG : 6'(pick);
                if ($urandom_range(0, 9) < 7 && m_tag[pick] >= 0)
                    commit(rnd_rd, 8'(m_tag[pick]), $urandom);
                else
                    commit(rnd_rd, 8'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 3) == 0) DPRF_rs1 = rnd_rd;
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
